bank_sc_ctrl: RTL and testbench
===============================

Name: bank_sc_ctrl

Overview:
Storage-controller front end that sits directly downstream of the bank issue-scheduling unit. It accepts one request per valid/ready handshake on the isu_sc interface. It sequences the two 128-bit beats of a cacheline into or out of a single-port data SRAM, and returns read data to the xbar response path through a valid/ready response port. It handles one request at a time, with no overlap between requests.

Parameters:
DATA_W, 128, width of one cacheline beat and of the SRAM word
CNT_W, 16, width of each performance counter (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
isu_sc_valid_i  in  1  request valid
isu_sc_ready_o  out  1  request ready
isu_sc_channel_id_i  in  2  requesting channel
isu_sc_opcode_i  in  3  0=READ, 2=LINEFILL, 3=LINEFILL_READ; all other values are illegal
isu_sc_set_way_offset_i  in  7  [6:4]=set, [3:1]=way, [0] ignored
isu_sc_wbuffer_id_i  in  8  carried to the response
isu_sc_xbar_rob_num_i  in  3  carried to the response
isu_sc_cacheline_dirty_offset0_i  in  2  carried to the response
isu_sc_cacheline_dirty_offset1_i  in  2  carried to the response
isu_sc_linefill_data_offset0_i  in  DATA_W  linefill beat 0
isu_sc_linefill_data_offset1_i  in  DATA_W  linefill beat 1
sc_sram_en_o  out  1  SRAM access enable
sc_sram_we_o  out  1  SRAM write enable
sc_sram_addr_o  out  7  {set, way, beat}
sc_sram_wdata_o  out  DATA_W  SRAM write data
sram_sc_rdata_i  in  DATA_W  SRAM read data, valid the cycle after a read enable
sc_xbar_resp_valid_o  out  1  response valid
sc_xbar_resp_ready_i  in  1  response ready
sc_xbar_resp_ch_id_o  out  2  response channel
sc_xbar_resp_rob_num_o  out  3  response ROB number
sc_xbar_resp_wbuffer_id_o  out  8  response write-buffer id
sc_xbar_resp_dirty_o  out  4  {dirty_offset1, dirty_offset0}
sc_xbar_resp_data_o  out  2*DATA_W  {beat1, beat0}
sc_err_o  out  1  one-cycle pulse on an illegal opcode
sc_perf_rd_cnt_o  out  CNT_W  count of READ requests
sc_perf_lf_cnt_o  out  CNT_W  count of LINEFILL and LINEFILL_READ requests

Behaviour:
- Reset values: FSM returns to IDLE. All registered outputs and data registers clear to 0: sc_sram_en_o, sc_sram_we_o, sc_xbar_resp_valid_o, sc_err_o, addr, data and both counters.
- isu_sc_ready_o = (state==IDLE) & ~rst_i. A request is accepted when valid & ready; accepted fields are captured into registers.
- FSM states: IDLE, WR0, WR1, RD0, RD1, RD2, RESP.
- Addressing: SRAM address = {set_way_offset[6:1], beat}, where beat 0 = offset0 and beat 1 = offset1.
- LINEFILL (acceptance at cycle T):
  - T+1, WR0: en=1, we=1, beat 0, wdata = offset0 data.
  - T+2, WR1: same with beat 1 and offset1 data.
  - T+3: IDLE, ready=1. Throughput is one linefill per 3 cycles.
- LINEFILL_READ: WR0 -> WR1 -> RESP. Response data = {offset1 data, offset0 data} as captured; the SRAM is not read back. resp_valid is first high at T+3.
- READ:
  - T+1, RD0: en=1, we=0, beat 0.
  - T+2, RD1: en=1, beat 1; beat 0 is captured from sram_sc_rdata_i.
  - T+3, RD2: en=0; beat 1 is captured.
  - T+4: RESP.
- RESP:
  - resp_valid=1 and all response fields are held stable until resp_ready is sampled high.
  - State returns to IDLE on the cycle after the handshake.
  - If resp_ready is already high on entry, the response completes in one cycle.
- Illegal opcode: the request is accepted (handshake completes) and state stays IDLE. sc_err_o=1 for exactly the next cycle; no SRAM access and no response. A back-to-back legal request may be accepted while sc_err_o is high.
- sc_sram_en_o is 0 in IDLE, RD2 and RESP. sc_sram_we_o is 1 only in WR0 and WR1.
- Reset mid-operation: any in-flight request is dropped with no response, no further SRAM access and no error. Ready rises the cycle after rst_i deasserts.
- Response fields other than resp_valid are don't-care when resp_valid=0, but hold their last value.

Optional Feature:
BANK_SC_PERF_CNT_EN
- Defined: sc_perf_rd_cnt_o increments on each accepted READ, and sc_perf_lf_cnt_o on each accepted LINEFILL or LINEFILL_READ. Illegal opcodes are not counted. Both counters saturate at all-ones and reset to 0.
- Undefined: both ports are tied to 0, and no counter flops exist.

Test Plan:
- LINEFILL to set 5, way 2 (offset 7'b1010100), beat 0 = 128'h1111, beat 1 = 128'h2222 -> T+1: addr 7'h54, we=1, wdata 128'h1111; T+2: addr 7'h55, wdata 128'h2222; ready=1 at T+3; no response.
- READ of the same line with ch 2, rob 5, SRAM model returning the written data -> en at T+1 and T+2 with addr 7'h54 then 7'h55; resp_valid at T+4 with data {128'h2222, 128'h1111}, ch 2, rob 5.
- READ with resp_ready held 0 for 3 cycles -> resp_valid and data stable for 4 cycles; ready=0 throughout; one handshake; IDLE the following cycle.
- LINEFILL_READ with beat 0 = 128'hA, beat 1 = 128'hB -> two SRAM writes, then resp data {128'hB, 128'hA} at T+3 with no SRAM read.
- Opcode 3'd5 -> accepted; sc_err_o high for exactly one cycle; sc_sram_en_o stays 0; no resp_valid; counters unchanged.
- rst_i asserted during RD1 -> next cycle en=0, resp_valid=0, state IDLE; with BANK_SC_PERF_CNT_EN defined, 3 READs plus 2 LINEFILLs give counters 3 and 2, and reset clears both to 0.

Source files
------------

// File: rtl/bank_sc_ctrl.sv
// Storage-controller front end: moves the two beats of a cacheline into or out of a single-port SRAM.
// Define BANK_SC_PERF_CNT_EN to add saturating READ and linefill request counters.
module bank_sc_ctrl #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                isu_sc_valid_i,
  output logic                isu_sc_ready_o,
  input  logic [1:0]          isu_sc_channel_id_i,
  input  logic [2:0]          isu_sc_opcode_i,
  input  logic [6:0]          isu_sc_set_way_offset_i,
  input  logic [7:0]          isu_sc_wbuffer_id_i,
  input  logic [2:0]          isu_sc_xbar_rob_num_i,
  input  logic [1:0]          isu_sc_cacheline_dirty_offset0_i,
  input  logic [1:0]          isu_sc_cacheline_dirty_offset1_i,
  input  logic [DATA_W-1:0]   isu_sc_linefill_data_offset0_i,
  input  logic [DATA_W-1:0]   isu_sc_linefill_data_offset1_i,
  output logic                sc_sram_en_o,
  output logic                sc_sram_we_o,
  output logic [6:0]          sc_sram_addr_o,
  output logic [DATA_W-1:0]   sc_sram_wdata_o,
  input  logic [DATA_W-1:0]   sram_sc_rdata_i,
  output logic                sc_xbar_resp_valid_o,
  input  logic                sc_xbar_resp_ready_i,
  output logic [1:0]          sc_xbar_resp_ch_id_o,
  output logic [2:0]          sc_xbar_resp_rob_num_o,
  output logic [7:0]          sc_xbar_resp_wbuffer_id_o,
  output logic [3:0]          sc_xbar_resp_dirty_o,
  output logic [2*DATA_W-1:0] sc_xbar_resp_data_o,
  output logic                sc_err_o,
  output logic [CNT_W-1:0]    sc_perf_rd_cnt_o,
  output logic [CNT_W-1:0]    sc_perf_lf_cnt_o
);

  localparam logic [2:0] OP_READ          = 3'd0;
  localparam logic [2:0] OP_LINEFILL      = 3'd2;
  localparam logic [2:0] OP_LINEFILL_READ = 3'd3;

  typedef enum logic [2:0] {IDLE, WR0, WR1, RD0, RD1, RD2, RESP} state_t;

  state_t            state_reg, state_next;
  logic [5:0]        set_way_reg;
  logic [1:0]        ch_reg;
  logic [2:0]        rob_reg;
  logic [7:0]        wbuf_reg;
  logic [3:0]        dirty_reg;
  logic [DATA_W-1:0] beat0_reg, beat1_reg;
  logic              lf_read_reg;
  logic              err_reg;

  logic accept, op_read, op_lf, op_legal;
  logic sram_en, sram_we, sram_beat;
  logic unused_offset_bit;

  assign unused_offset_bit = isu_sc_set_way_offset_i[0];

  assign isu_sc_ready_o = (state_reg == IDLE) && !rst_i;
  assign accept         = isu_sc_valid_i && isu_sc_ready_o;
  assign op_read        = (isu_sc_opcode_i == OP_READ);
  assign op_lf          = (isu_sc_opcode_i == OP_LINEFILL) || (isu_sc_opcode_i == OP_LINEFILL_READ);
  assign op_legal       = op_read || op_lf;

  always_comb begin
    state_next = state_reg;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_beat  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept && op_read)    state_next = RD0;
        else if (accept && op_lf) state_next = WR0;
      end
      WR0: begin
        sram_en    = 1'b1;
        sram_we    = 1'b1;
        state_next = WR1;
      end
      WR1: begin
        sram_en    = 1'b1;
        sram_we    = 1'b1;
        sram_beat  = 1'b1;
        state_next = lf_read_reg ? RESP : IDLE;
      end
      RD0: begin
        sram_en    = 1'b1;
        state_next = RD1;
      end
      RD1: begin
        sram_en    = 1'b1;
        sram_beat  = 1'b1;
        state_next = RD2;
      end
      RD2:     state_next = RESP;
      RESP:    if (sc_xbar_resp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read beats land one cycle after their enable: beat 0 in RD1, beat 1 in RD2.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      set_way_reg <= '0;
      ch_reg      <= '0;
      rob_reg     <= '0;
      wbuf_reg    <= '0;
      dirty_reg   <= '0;
      beat0_reg   <= '0;
      beat1_reg   <= '0;
      lf_read_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= accept && !op_legal;
      if (accept && op_legal) begin
        set_way_reg <= isu_sc_set_way_offset_i[6:1];
        ch_reg      <= isu_sc_channel_id_i;
        rob_reg     <= isu_sc_xbar_rob_num_i;
        wbuf_reg    <= isu_sc_wbuffer_id_i;
        dirty_reg   <= {isu_sc_cacheline_dirty_offset1_i, isu_sc_cacheline_dirty_offset0_i};
        beat0_reg   <= isu_sc_linefill_data_offset0_i;
        beat1_reg   <= isu_sc_linefill_data_offset1_i;
        lf_read_reg <= (isu_sc_opcode_i == OP_LINEFILL_READ);
      end
      if (state_reg == RD1) beat0_reg <= sram_sc_rdata_i;
      if (state_reg == RD2) beat1_reg <= sram_sc_rdata_i;
    end
  end

  assign sc_sram_en_o    = sram_en;
  assign sc_sram_we_o    = sram_we;
  assign sc_sram_addr_o  = {set_way_reg, sram_beat};
  assign sc_sram_wdata_o = sram_beat ? beat1_reg : beat0_reg;

  assign sc_xbar_resp_valid_o      = (state_reg == RESP);
  assign sc_xbar_resp_ch_id_o      = ch_reg;
  assign sc_xbar_resp_rob_num_o    = rob_reg;
  assign sc_xbar_resp_wbuffer_id_o = wbuf_reg;
  assign sc_xbar_resp_dirty_o      = dirty_reg;
  assign sc_xbar_resp_data_o       = {beat1_reg, beat0_reg};
  assign sc_err_o                  = err_reg;

`ifdef BANK_SC_PERF_CNT_EN
  logic [CNT_W-1:0] rd_cnt_reg, lf_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_reg <= '0;
      lf_cnt_reg <= '0;
    end else begin
      if (accept && op_read && (rd_cnt_reg != '1)) rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
      if (accept && op_lf && (lf_cnt_reg != '1))   lf_cnt_reg <= lf_cnt_reg + CNT_W'(1);
    end
  end

  assign sc_perf_rd_cnt_o = rd_cnt_reg;
  assign sc_perf_lf_cnt_o = lf_cnt_reg;
`else
  assign sc_perf_rd_cnt_o = '0;
  assign sc_perf_lf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bank_sc_ctrl.sv
// Scoreboard bench for bank_sc_ctrl: a request-level model queues expected SRAM beats,
// responses and error pulses with their cycle, and a monitor consumes them as the DUT shows them.
module tb_bank_sc_ctrl;
  localparam int DW = 128;
  localparam int CW = 16;
`ifdef BANK_SC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            isu_sc_valid_i = 1'b0;
  logic            isu_sc_ready_o;
  logic [1:0]      isu_sc_channel_id_i = '0;
  logic [2:0]      isu_sc_opcode_i = '0;
  logic [6:0]      isu_sc_set_way_offset_i = '0;
  logic [7:0]      isu_sc_wbuffer_id_i = '0;
  logic [2:0]      isu_sc_xbar_rob_num_i = '0;
  logic [1:0]      isu_sc_cacheline_dirty_offset0_i = '0;
  logic [1:0]      isu_sc_cacheline_dirty_offset1_i = '0;
  logic [DW-1:0]   isu_sc_linefill_data_offset0_i = '0;
  logic [DW-1:0]   isu_sc_linefill_data_offset1_i = '0;
  logic            sc_sram_en_o, sc_sram_we_o;
  logic [6:0]      sc_sram_addr_o;
  logic [DW-1:0]   sc_sram_wdata_o;
  logic [DW-1:0]   sram_sc_rdata_i = '0;
  logic            sc_xbar_resp_valid_o;
  logic            sc_xbar_resp_ready_i = 1'b0;
  logic [1:0]      sc_xbar_resp_ch_id_o;
  logic [2:0]      sc_xbar_resp_rob_num_o;
  logic [7:0]      sc_xbar_resp_wbuffer_id_o;
  logic [3:0]      sc_xbar_resp_dirty_o;
  logic [2*DW-1:0] sc_xbar_resp_data_o;
  logic            sc_err_o;
  logic [CW-1:0]   sc_perf_rd_cnt_o, sc_perf_lf_cnt_o;

  bank_sc_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .isu_sc_valid_i(isu_sc_valid_i), .isu_sc_ready_o(isu_sc_ready_o),
    .isu_sc_channel_id_i(isu_sc_channel_id_i), .isu_sc_opcode_i(isu_sc_opcode_i),
    .isu_sc_set_way_offset_i(isu_sc_set_way_offset_i), .isu_sc_wbuffer_id_i(isu_sc_wbuffer_id_i),
    .isu_sc_xbar_rob_num_i(isu_sc_xbar_rob_num_i),
    .isu_sc_cacheline_dirty_offset0_i(isu_sc_cacheline_dirty_offset0_i),
    .isu_sc_cacheline_dirty_offset1_i(isu_sc_cacheline_dirty_offset1_i),
    .isu_sc_linefill_data_offset0_i(isu_sc_linefill_data_offset0_i),
    .isu_sc_linefill_data_offset1_i(isu_sc_linefill_data_offset1_i),
    .sc_sram_en_o(sc_sram_en_o), .sc_sram_we_o(sc_sram_we_o), .sc_sram_addr_o(sc_sram_addr_o),
    .sc_sram_wdata_o(sc_sram_wdata_o), .sram_sc_rdata_i(sram_sc_rdata_i),
    .sc_xbar_resp_valid_o(sc_xbar_resp_valid_o), .sc_xbar_resp_ready_i(sc_xbar_resp_ready_i),
    .sc_xbar_resp_ch_id_o(sc_xbar_resp_ch_id_o), .sc_xbar_resp_rob_num_o(sc_xbar_resp_rob_num_o),
    .sc_xbar_resp_wbuffer_id_o(sc_xbar_resp_wbuffer_id_o), .sc_xbar_resp_dirty_o(sc_xbar_resp_dirty_o),
    .sc_xbar_resp_data_o(sc_xbar_resp_data_o), .sc_err_o(sc_err_o),
    .sc_perf_rd_cnt_o(sc_perf_rd_cnt_o), .sc_perf_lf_cnt_o(sc_perf_lf_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Single-port SRAM seen by the DUT: read data appears the cycle after the enable.
  logic [DW-1:0] sram [0:127];
  always @(posedge clk_i) begin
    if (sc_sram_en_o && sc_sram_we_o)  sram[sc_sram_addr_o] <= sc_sram_wdata_o;
    if (sc_sram_en_o && !sc_sram_we_o) sram_sc_rdata_i <= sram[sc_sram_addr_o];
  end

  typedef struct {int cyc; logic [6:0] addr; logic [DW-1:0] data;} acc_t;
  typedef struct {int first; logic [1:0] ch; logic [2:0] rob; logic [7:0] wb; logic [3:0] dirty; logic [2*DW-1:0] data;} resp_t;

  acc_t  exp_wr[$];
  acc_t  exp_rd[$];
  resp_t exp_resp[$];
  int    exp_err[$];

  logic [DW-1:0] mdl_mem [int];
  int            lines[$];
  int            mdl_rd = 0, mdl_lf = 0;

  int checks = 0, errors = 0;
  logic [2*DW-1:0] last_resp_data = '0;
  logic [1:0]      last_resp_ch = '0;
  logic [2:0]      last_resp_rob = '0;
  int              last_resp_cycles = 0;

  bit rdy_force_en = 1'b1, rdy_force_val = 1'b1;

  function automatic void chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endfunction

  // Request-level model: each accepted request expands into timed expected events.
  task automatic issue(input logic [2:0] op, input logic [1:0] ch, input logic [6:0] swo,
                       input logic [7:0] wb, input logic [2:0] rob, input logic [1:0] d0f,
                       input logic [1:0] d1f, input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                       output int t);
    int n;
    int base;
    acc_t a;
    resp_t r;
    n = 0;
    t = -1;
    isu_sc_opcode_i = op; isu_sc_channel_id_i = ch; isu_sc_set_way_offset_i = swo;
    isu_sc_wbuffer_id_i = wb; isu_sc_xbar_rob_num_i = rob;
    isu_sc_cacheline_dirty_offset0_i = d0f; isu_sc_cacheline_dirty_offset1_i = d1f;
    isu_sc_linefill_data_offset0_i = b0; isu_sc_linefill_data_offset1_i = b1;
    isu_sc_valid_i = 1'b1;
    @(negedge clk_i);
    while (!isu_sc_ready_o && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    if (!isu_sc_ready_o) begin
      fail("accept_timeout");
    end else begin
      t = cyc;
      base = {25'd0, swo[6:1], 1'b0};
      r.ch = ch; r.rob = rob; r.wb = wb; r.dirty = {d1f, d0f};
      if (op == 3'd0) begin
        if (mdl_rd < 65535) mdl_rd++;
        a.data = '0;
        a.cyc = t + 1; a.addr = 7'(base);     exp_rd.push_back(a);
        a.cyc = t + 2; a.addr = 7'(base + 1); exp_rd.push_back(a);
        r.first = t + 4;
        r.data = {mdl_mem[base + 1], mdl_mem[base]};
        exp_resp.push_back(r);
      end else if (op == 3'd2 || op == 3'd3) begin
        if (mdl_lf < 65535) mdl_lf++;
        a.cyc = t + 1; a.addr = 7'(base);     a.data = b0; exp_wr.push_back(a);
        a.cyc = t + 2; a.addr = 7'(base + 1); a.data = b1; exp_wr.push_back(a);
        mdl_mem[base] = b0;
        mdl_mem[base + 1] = b1;
        lines.push_back(base);
        if (op == 3'd3) begin
          r.first = t + 3;
          r.data = {b1, b0};
          exp_resp.push_back(r);
        end
      end else begin
        exp_err.push_back(t + 1);
      end
    end
    @(posedge clk_i);
    #1;
    isu_sc_valid_i = 1'b0;
    isu_sc_linefill_data_offset0_i = {$urandom, $urandom, $urandom, $urandom};
    isu_sc_linefill_data_offset1_i = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while ((exp_wr.size() + exp_rd.size() + exp_resp.size() + exp_err.size() != 0 ||
                sc_xbar_resp_valid_o) && n < 300);
    if (n >= 300) fail("drain_timeout");
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      sc_xbar_resp_ready_i = rdy_force_en ? rdy_force_val : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: consumes expectations whenever the DUT presents an SRAM beat, response or error.
  initial begin : monitor
    acc_t a;
    resp_t r;
    logic prev_valid, prev_ready;
    logic [272:0] prev_fields, cur_fields;
    int resp_cycles;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_fields = '0; resp_cycles = 0;
    forever begin
      @(negedge clk_i);
      if (sc_sram_en_o && sc_sram_we_o) begin
        if (exp_wr.size() == 0) fail("unexpected_sram_write");
        else begin
          a = exp_wr.pop_front();
          chk("wr_cycle", cyc, a.cyc);
          chk("wr_addr", sc_sram_addr_o, a.addr);
          chk("wr_data", sc_sram_wdata_o, a.data);
        end
      end else if (sc_sram_en_o) begin
        if (exp_rd.size() == 0) fail("unexpected_sram_read");
        else begin
          a = exp_rd.pop_front();
          chk("rd_cycle", cyc, a.cyc);
          chk("rd_addr", sc_sram_addr_o, a.addr);
        end
      end
      while (exp_wr.size() > 0 && exp_wr[0].cyc < cyc) begin fail("sram_write_missing"); void'(exp_wr.pop_front()); end
      while (exp_rd.size() > 0 && exp_rd[0].cyc < cyc) begin fail("sram_read_missing"); void'(exp_rd.pop_front()); end

      cur_fields = {sc_xbar_resp_ch_id_o, sc_xbar_resp_rob_num_o, sc_xbar_resp_wbuffer_id_o,
                    sc_xbar_resp_dirty_o, sc_xbar_resp_data_o};
      if (sc_xbar_resp_valid_o) begin
        chk("req_ready_during_resp", isu_sc_ready_o, 1'b0);
        if (prev_valid && prev_ready) fail("resp_valid_after_handshake");
        if (!prev_valid || prev_ready) begin
          resp_cycles = 0;
          if (exp_resp.size() == 0) fail("unexpected_resp");
          else chk("resp_first_cycle", cyc, exp_resp[0].first);
        end else begin
          chk("resp_stable", cur_fields, prev_fields);
        end
        resp_cycles++;
        if (sc_xbar_resp_ready_i && exp_resp.size() > 0) begin
          r = exp_resp.pop_front();
          chk("resp_ch", sc_xbar_resp_ch_id_o, r.ch);
          chk("resp_rob", sc_xbar_resp_rob_num_o, r.rob);
          chk("resp_wbuf", sc_xbar_resp_wbuffer_id_o, r.wb);
          chk("resp_dirty", sc_xbar_resp_dirty_o, r.dirty);
          chk("resp_data", sc_xbar_resp_data_o, r.data);
          last_resp_data = sc_xbar_resp_data_o;
          last_resp_ch = sc_xbar_resp_ch_id_o;
          last_resp_rob = sc_xbar_resp_rob_num_o;
          last_resp_cycles = resp_cycles;
        end
      end else if (exp_resp.size() > 0 && cyc > exp_resp[0].first) begin
        fail("resp_missing");
        void'(exp_resp.pop_front());
      end
      prev_valid = sc_xbar_resp_valid_o;
      prev_ready = sc_xbar_resp_ready_i;
      prev_fields = cur_fields;

      if (sc_err_o) begin
        if (exp_err.size() > 0 && exp_err[0] == cyc) begin
          checks++;
          void'(exp_err.pop_front());
        end else fail("unexpected_err_pulse");
      end
      while (exp_err.size() > 0 && exp_err[0] < cyc) begin fail("err_pulse_missing"); void'(exp_err.pop_front()); end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin : stim
    int t1, t2, n, r, base;
    logic [2:0] op;
    logic [6:0] swo;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("ready_in_reset", isu_sc_ready_o, 1'b0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("ready_after_reset", isu_sc_ready_o, 1'b1);
    chk("en_after_reset", sc_sram_en_o, 1'b0);
    chk("we_after_reset", sc_sram_we_o, 1'b0);
    chk("addr_after_reset", sc_sram_addr_o, 7'h00);
    chk("resp_valid_after_reset", sc_xbar_resp_valid_o, 1'b0);
    chk("err_after_reset", sc_err_o, 1'b0);
    chk("perf_rd_after_reset", sc_perf_rd_cnt_o, 16'd0);
    chk("perf_lf_after_reset", sc_perf_lf_cnt_o, 16'd0);
    @(posedge clk_i); #1;

    // Linefill to set 5 way 2, then a back-to-back linefill to measure throughput.
    issue(3'd2, 2'd0, 7'b1010100, 8'h11, 3'd0, 2'd0, 2'd0, 128'h1111, 128'h2222, t1);
    issue(3'd2, 2'd1, 7'h20, 8'h12, 3'd1, 2'd1, 2'd2, 128'hC0DE, 128'hBEEF, t2);
    chk("linefill_throughput", t2, t1 + 3);
    wait_drain();

    issue(3'd0, 2'd2, 7'b1010100, 8'h3C, 3'd5, 2'd1, 2'd2, '0, '0, t1);
    wait_drain();
    chk("read_back_data", last_resp_data, {128'h2222, 128'h1111});
    chk("read_back_ch", last_resp_ch, 2'd2);
    chk("read_back_rob", last_resp_rob, 3'd5);

    // Response back-pressure: ready low for three cycles after valid rises.
    rdy_force_val = 1'b0;
    issue(3'd0, 2'd1, 7'h21, 8'h44, 3'd3, 2'd3, 2'd0, '0, '0, t1);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!sc_xbar_resp_valid_o && n < 20);
    if (!sc_xbar_resp_valid_o) fail("stall_resp_timeout");
    repeat (2) @(negedge clk_i);
    rdy_force_val = 1'b1;
    wait_drain();
    chk("stall_valid_cycles", last_resp_cycles, 4);
    chk("stall_data", last_resp_data, {128'hBEEF, 128'hC0DE});

    issue(3'd3, 2'd3, 7'h37, 8'h99, 3'd7, 2'd2, 2'd1, 128'hA, 128'hB, t1);
    wait_drain();
    chk("lf_read_data", last_resp_data, {128'hB, 128'hA});

    // Illegal opcode followed immediately by a legal request.
    issue(3'd5, 2'd0, 7'h10, 8'h01, 3'd1, 2'd0, 2'd0, '0, '0, t1);
    issue(3'd2, 2'd0, 7'h10, 8'h02, 3'd2, 2'd0, 2'd0, 128'h5, 128'h6, t2);
    chk("err_back_to_back_accept", t2, t1 + 1);
    wait_drain();

    rdy_force_en = 1'b0;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      swo = 7'($urandom);
      if (r <= 2) begin
        op = 3'd0;
        base = lines[$urandom_range(0, lines.size() - 1)];
        swo = {base[6:1], 1'($urandom)};
      end else if (r <= 5) op = 3'd2;
      else if (r <= 7) op = 3'd3;
      else begin
        n = $urandom_range(0, 4);
        op = (n == 0) ? 3'd1 : 3'(n + 3);
      end
      issue(op, 2'($urandom), swo, 8'($urandom), 3'($urandom), 2'($urandom), 2'($urandom),
            {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, t1);
      n = $urandom_range(0, 2);
      repeat (n) begin @(posedge clk_i); #1; end
    end
    wait_drain();
    chk("perf_rd_count", sc_perf_rd_cnt_o, PERF ? mdl_rd : 0);
    chk("perf_lf_count", sc_perf_lf_cnt_o, PERF ? mdl_lf : 0);

    // Reset while the read is in RD1: the request is dropped silently.
    rdy_force_en = 1'b1;
    rdy_force_val = 1'b1;
    issue(3'd0, 2'd1, 7'b1010100, 8'h77, 3'd4, 2'd0, 2'd0, '0, '0, t1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    exp_resp.delete();
    exp_rd.delete();
    mdl_rd = 0;
    mdl_lf = 0;
    @(negedge clk_i);
    chk("en_after_midop_reset", sc_sram_en_o, 1'b0);
    chk("resp_valid_after_midop_reset", sc_xbar_resp_valid_o, 1'b0);
    chk("ready_low_during_reset", isu_sc_ready_o, 1'b0);
    chk("perf_rd_cleared", sc_perf_rd_cnt_o, 16'd0);
    chk("perf_lf_cleared", sc_perf_lf_cnt_o, 16'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("ready_after_midop_reset", isu_sc_ready_o, 1'b1);
    repeat (5) @(negedge clk_i);
    @(posedge clk_i); #1;
    issue(3'd3, 2'd2, 7'h66, 8'h5A, 3'd6, 2'd1, 2'd3, 128'hF00D, 128'hCAFE, t1);
    wait_drain();
    chk("post_reset_lf_read", last_resp_data, {128'hCAFE, 128'hF00D});
    chk("perf_lf_post_reset", sc_perf_lf_cnt_o, PERF ? 1 : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
